// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake and data bundle for pipelined_barrel_shifter.
// master drives operands and out_ready; slave (the shifter) drives results and status.
interface pipelined_barrel_shifter_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned TAG_W   = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         mode;
    logic [SHAMT_W-1:0] sh_amt;
    logic [WIDTH-1:0]   d_in;
    logic [TAG_W-1:0]   tag_in;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   d_out;
    logic [TAG_W-1:0]   tag_out;
    logic               busy;

    modport master (
        output in_valid, mode, sh_amt, d_in, tag_in, out_ready,
        input  in_ready, out_valid, d_out, tag_out, busy
    );

    modport slave (
        input  in_valid, mode, sh_amt, d_in, tag_in, out_ready,
        output in_ready, out_valid, d_out, tag_out, busy
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined logarithmic shifter (SLL/SRL/SRA, optional ROR) with a register slice every
// REG_EVERY stages and valid/ready flow control. Define ROTATE_EN to build the rotate path.
module pipelined_barrel_shifter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SHAMT_W   = 5,
    parameter int unsigned REG_EVERY = 1,
    parameter int unsigned TAG_W     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int unsigned NREG = (SHAMT_W + REG_EVERY - 1) / REG_EVERY;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    logic [NREG-1:0]    valid_q, valid_d;
    logic [WIDTH-1:0]   data_q [NREG];
    logic [WIDTH-1:0]   data_d [NREG];
    logic [SHAMT_W-1:0] amt_q  [NREG];
    logic [SHAMT_W-1:0] amt_d  [NREG];
    mode_e              mode_q [NREG];
    mode_e              mode_d [NREG];
    logic [TAG_W-1:0]   tag_q  [NREG];
    logic [TAG_W-1:0]   tag_d  [NREG];
    logic               sign_q [NREG];
    logic               sign_d [NREG];

    logic [NREG-1:0]    src_valid;
    logic [WIDTH-1:0]   src_data [NREG];
    logic [SHAMT_W-1:0] src_amt  [NREG];
    mode_e              src_mode [NREG];
    logic [TAG_W-1:0]   src_tag  [NREG];
    logic               src_sign [NREG];
    logic [WIDTH-1:0]   shf      [NREG];
    logic [NREG-1:0]    rdy;

    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input int unsigned      sa,
        input mode_e            md,
        input logic             sgn
    );
        logic [2*WIDTH-1:0] ext;
        logic [WIDTH-1:0]   r;
        ext = {{WIDTH{sgn}}, d} >> sa;
        case (md)
            MODE_SLL: r = d << sa;
            MODE_SRA: r = ext[WIDTH-1:0];
`ifdef ROTATE_EN
            MODE_ROR: r = (d >> sa) | (d << (WIDTH - sa));
`endif
            default:  r = d >> sa;
        endcase
        return r;
    endfunction

    // Slice i may load when any slice from i to the output is empty or the output drains;
    // written in closed form so the ready chain never reads itself.
    always_comb begin
        logic full;
        full = 1'b1;
        for (int unsigned i = 0; i < NREG; i++) begin
            full = 1'b1;
            for (int unsigned j = i; j < NREG; j++) begin
                full = full & valid_q[j];
            end
            rdy[i] = bus.out_ready | ~full;
        end
    end

    always_comb begin
        src_valid[0] = bus.in_valid;
        src_data[0]  = bus.d_in;
        src_amt[0]   = bus.sh_amt;
        src_mode[0]  = mode_e'(bus.mode);
        src_tag[0]   = bus.tag_in;
        src_sign[0]  = bus.d_in[WIDTH-1];
        for (int unsigned i = 1; i < NREG; i++) begin
            src_valid[i] = valid_q[i-1];
            src_data[i]  = data_q[i-1];
            src_amt[i]   = amt_q[i-1];
            src_mode[i]  = mode_q[i-1];
            src_tag[i]   = tag_q[i-1];
            src_sign[i]  = sign_q[i-1];
        end
    end

    // Stage k (MSB-first) lives in the slice k / REG_EVERY and shifts by 2^(SHAMT_W-1-k).
    always_comb begin
        valid_d = valid_q;
        for (int unsigned i = 0; i < NREG; i++) begin
            data_d[i] = data_q[i];
            amt_d[i]  = amt_q[i];
            mode_d[i] = mode_q[i];
            tag_d[i]  = tag_q[i];
            sign_d[i] = sign_q[i];
        end
        for (int unsigned i = 0; i < NREG; i++) begin
            shf[i] = src_data[i];
            for (int unsigned k = 0; k < SHAMT_W; k++) begin
                if ((k / REG_EVERY) == i && src_amt[i][SHAMT_W-1-k]) begin
                    shf[i] = shift_stage(shf[i], 32'd1 << (SHAMT_W-1-k), src_mode[i], src_sign[i]);
                end
            end
            if (rdy[i]) begin
                valid_d[i] = src_valid[i];
                if (src_valid[i]) begin
                    data_d[i] = shf[i];
                    amt_d[i]  = src_amt[i];
                    mode_d[i] = src_mode[i];
                    tag_d[i]  = src_tag[i];
                    sign_d[i] = src_sign[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
                amt_q[i]  <= '0;
                mode_q[i] <= MODE_SLL;
                tag_q[i]  <= '0;
                sign_q[i] <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned i = 0; i < NREG; i++) begin
                data_q[i] <= data_d[i];
                amt_q[i]  <= amt_d[i];
                mode_q[i] <= mode_d[i];
                tag_q[i]  <= tag_d[i];
                sign_q[i] <= sign_d[i];
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = valid_q[NREG-1];
    assign bus.d_out     = data_q[NREG-1];
    assign bus.tag_out   = tag_q[NREG-1];
    assign bus.busy      = |valid_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter: directed table, back-pressure,
// throughput, mid-stream reset and randomized traffic against an arithmetic reference.
module tb_pipelined_barrel_shifter;
    parameter int unsigned REG_EVERY = 1;
    localparam int unsigned LAT = (5 + REG_EVERY - 1) / REG_EVERY;

    typedef struct {
        logic [1:0]  mode;
        logic [4:0]  amt;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_barrel_shifter_if #(.WIDTH(32), .SHAMT_W(5), .TAG_W(4)) bif ();

    pipelined_barrel_shifter #(
        .WIDTH(32), .SHAMT_W(5), .REG_EVERY(REG_EVERY), .TAG_W(4)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bif)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [35:0] sb[$];
    logic        acc, ofire, ird, prev_stall;
    logic [31:0] od, prev_d;
    logic [3:0]  otag, prev_t;
    vec_t        vecs[12];

    function automatic logic [31:0] model(input logic [1:0] m, input logic [4:0] a, input logic [31:0] d);
        int unsigned n;
        n = a;
        case (m)
            2'b00: return d << n;
            2'b01: return d >> n;
            2'b10: return $signed(d) >>> n;
            default: begin
`ifdef ROTATE_EN
                if (n == 0) return d;
                return (d >> n) | (d << (32 - n));
`else
                return d >> n;
`endif
            end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit later, update the scoreboard.
    task automatic cycle(input logic iv, input logic [1:0] m, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] t, input logic ordy);
        logic [35:0] e;
        @(negedge clk);
        bif.in_valid = iv; bif.mode = m; bif.sh_amt = a;
        bif.d_in = d; bif.tag_in = t; bif.out_ready = ordy;
        #1;
        chk("busy", {31'd0, bif.busy}, {31'd0, sb.size() != 0});
        chk("in_ready", {31'd0, bif.in_ready}, {31'd0, ordy || (sb.size() < LAT)});
        if (prev_stall) begin
            chk("hold_valid", {31'd0, bif.out_valid}, 32'd1);
            chk("hold_data", bif.d_out, prev_d);
            chk("hold_tag", {28'd0, bif.tag_out}, {28'd0, prev_t});
        end
        ofire = 1'b0;
        if (bif.out_valid) begin
            chk("no_spurious", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb[0];
                chk("d_out", bif.d_out, e[31:0]);
                chk("tag_out", {28'd0, bif.tag_out}, {28'd0, e[35:32]});
                if (ordy) void'(sb.pop_front());
            end
            ofire = ordy;
        end
        od = bif.d_out; otag = bif.tag_out; ird = bif.in_ready;
        prev_stall = bif.out_valid && !ordy;
        prev_d = bif.d_out; prev_t = bif.tag_out;
        acc = iv && bif.in_ready;
        if (acc) sb.push_back({t, model(m, a, d)});
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sb.size() != 0 && b < 64) begin
            cycle(1'b0, 2'b00, 5'd0, 32'd0, 4'd0, 1'b1);
            b++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, recv, c, n, first_acc, last_acc, first_out, last_out;
        logic dropped;

        vecs[0]  = '{2'b00, 5'd4,  32'h8000_00F1, 32'h0000_0F10};
        vecs[1]  = '{2'b01, 5'd4,  32'h8000_00F1, 32'h0800_000F};
        vecs[2]  = '{2'b10, 5'd4,  32'h8000_00F1, 32'hF800_000F};
`ifdef ROTATE_EN
        vecs[3]  = '{2'b11, 5'd4,  32'h8000_00F1, 32'h1800_000F};
`else
        vecs[3]  = '{2'b11, 5'd4,  32'h8000_00F1, 32'h0800_000F};
`endif
        vecs[4]  = '{2'b00, 5'd0,  32'hA5C3_1E69, 32'hA5C3_1E69};
        vecs[5]  = '{2'b01, 5'd0,  32'hA5C3_1E69, 32'hA5C3_1E69};
        vecs[6]  = '{2'b10, 5'd0,  32'hA5C3_1E69, 32'hA5C3_1E69};
        vecs[7]  = '{2'b11, 5'd0,  32'hA5C3_1E69, 32'hA5C3_1E69};
        vecs[8]  = '{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[9]  = '{2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000};
        vecs[10] = '{2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001};
        vecs[11] = '{2'b10, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000};

        prev_stall = 1'b0;
        rst_n = 1'b0;
        bif.in_valid = 1'b0; bif.mode = 2'b00; bif.sh_amt = '0;
        bif.d_in = '0; bif.tag_in = '0; bif.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
        chk("rst_d_out", bif.d_out, 32'd0);
        chk("rst_tag_out", {28'd0, bif.tag_out}, 32'd0);
        chk("rst_busy", {31'd0, bif.busy}, 32'd0);
        rst_n = 1'b1;

        // Directed table: one beat at a time, also checks single-beat latency
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, vecs[i].mode, vecs[i].amt, vecs[i].d, 4'(i), 1'b1);
            chk("tbl_accept", {31'd0, acc}, 32'd1);
            n = 0;
            ofire = 1'b0;
            while (!ofire && n < 20) begin
                cycle(1'b0, 2'b00, 5'd0, 32'd0, 4'd0, 1'b1);
                n++;
            end
            chk("tbl_latency", 32'(n), LAT);
            chk("tbl_result", od, vecs[i].exp);
        end

        // Back-pressure: 8 beats, output stalled during cycles 3..12
        sent = 0; recv = 0; dropped = 1'b0;
        for (c = 0; c < 80 && recv < 8; c++) begin
            cycle(sent < 8, 2'(c), 5'(c), $urandom, 4'(sent), !(c >= 3 && c <= 12));
            if (sent < 8 && !ird && !dropped) begin
                dropped = 1'b1;
                chk("bp_full_depth", 32'(sb.size()), LAT);
            end
            if (acc) sent++;
            if (ofire) begin
                chk("bp_tag_order", {28'd0, otag}, 32'(recv));
                recv++;
            end
        end
        chk("bp_in_ready_dropped", {31'd0, dropped}, 32'd1);
        chk("bp_recv", 32'(recv), 32'd8);
        drain();

        // Throughput: continuous stream of 100 beats
        sent = 0; recv = 0; first_acc = -1; last_acc = -1; first_out = -1; last_out = -1;
        for (c = 0; c < 300 && recv < 100; c++) begin
            cycle(sent < 100, 2'($urandom), 5'($urandom), $urandom, 4'(sent), 1'b1);
            if (acc) begin
                if (first_acc < 0) first_acc = c;
                last_acc = c;
                sent++;
            end
            if (ofire) begin
                if (first_out < 0) first_out = c;
                last_out = c;
                chk("tp_tag_order", {28'd0, otag}, 32'(recv % 16));
                recv++;
            end
        end
        chk("tp_recv", 32'(recv), 32'd100);
        chk("tp_accept_span", 32'(last_acc - first_acc), 32'd99);
        chk("tp_first_latency", 32'(first_out - first_acc), LAT);
        chk("tp_output_span", 32'(last_out - first_out), 32'd99);

        // Mid-stream reset with beats in flight
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'b01, 5'd1, $urandom, 4'(i), 1'b0);
        n = 0;
        while (!bif.out_valid && n < 10) begin
            cycle(1'b0, 2'b00, 5'd0, 32'd0, 4'd0, 1'b0);
            n++;
        end
        chk("mr_out_valid_before", {31'd0, bif.out_valid}, 32'd1);
        @(negedge clk);
        bif.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mr_out_valid", {31'd0, bif.out_valid}, 32'd0);
        chk("mr_d_out", bif.d_out, 32'd0);
        chk("mr_busy", {31'd0, bif.busy}, 32'd0);
        sb.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr_in_ready", {31'd0, bif.in_ready}, 32'd1);
        repeat (LAT + 4) cycle(1'b0, 2'b00, 5'd0, 32'd0, 4'd0, 1'b1);

        // Randomized traffic
        sent = 0;
        for (c = 0; c < 60000 && sent < 10000; c++) begin
            logic [31:0] d;
            d = $urandom;
            if ($urandom_range(0, 15) == 0) d = 32'h8000_0000;
            cycle($urandom_range(0, 3) != 0, 2'($urandom), 5'($urandom), d,
                  4'(sent), $urandom_range(0, 3) != 0);
            if (acc) sent++;
        end
        chk("rnd_sent", 32'(sent), 32'd10000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
